pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } ctrl_state_e;

  localparam int unsigned FLUSH_CYCLES_DEFAULT = 1;
  localparam int unsigned MAX_STALL_DEFAULT    = 1;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
  } ctrl_en_t;

  localparam ctrl_en_t CTRL_EN_RUN    = ctrl_en_t'(6'b110101);
  localparam ctrl_en_t CTRL_EN_STALL  = ctrl_en_t'(6'b000111);
  localparam ctrl_en_t CTRL_EN_REDIR  = ctrl_en_t'(6'b111111);
  localparam ctrl_en_t CTRL_EN_FLUSH  = ctrl_en_t'(6'b111101);
  localparam ctrl_en_t CTRL_EN_FREEZE = ctrl_en_t'(6'b000000);
  localparam ctrl_en_t CTRL_EN_RESET  = ctrl_en_t'(6'b001010);

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall, redirect flush and memory freeze sequencing.
// state  | meaning
// RUN    | normal flow, all stages advance
// STALL  | previous cycle inserted a load-use bubble
// FLUSH  | post-redirect IF/ID flush countdown in progress
// FREEZE | memory busy, whole pipe held; pre-freeze state saved
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int unsigned MAX_STALL    = MAX_STALL_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ctrl_stall,
  input  logic        i_ctrl_br_taken_execute,
  input  logic        i_ctrl_mem_busy,
  input  logic        i_ctrl_cnt_clr,
  output logic        o_ctrl_pc_en,
  output logic        o_ctrl_if_id_en,
  output logic        o_ctrl_if_id_flush,
  output logic        o_ctrl_id_ex_en,
  output logic        o_ctrl_id_ex_flush,
  output logic        o_ctrl_ex_mem_en,
  output logic [1:0]  o_ctrl_state,
  output logic [31:0] o_ctrl_stall_cnt,
  output logic [31:0] o_ctrl_flush_cnt,
  output logic [31:0] o_ctrl_freeze_cnt,
  output logic        o_ctrl_err
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  ctrl_state_e state_q, state_d, saved_q, saved_d, eff_state;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] consec_q, consec_d;
  logic        err_q, err_d;
  logic        stall_ev, flush_ev, freeze_ev;
  ctrl_en_t    en;

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    consec_d  = consec_q;
    err_d     = err_q;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;
    freeze_ev = 1'b0;
    en        = CTRL_EN_FREEZE;
    // Leaving FREEZE continues from the saved state in the same cycle.
    eff_state = (state_q == ST_FREEZE) ? saved_q : state_q;

    if (i_reset) begin
      en = CTRL_EN_RESET;
    end else if (i_ctrl_mem_busy) begin
      freeze_ev = 1'b1;
      state_d   = ST_FREEZE;
      if (state_q != ST_FREEZE) saved_d = state_q;
    end else if (i_ctrl_br_taken_execute) begin
      en       = CTRL_EN_REDIR;
      flush_ev = 1'b1;
      cnt_d    = FLUSH_LOAD;
      state_d  = (FLUSH_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
      consec_d = '0;
    end else if (eff_state == ST_FLUSH) begin
      en       = CTRL_EN_FLUSH;
      cnt_d    = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
      state_d  = (cnt_q <= 2'd1) ? ST_RUN : ST_FLUSH;
      consec_d = '0;
    end else if (i_ctrl_stall) begin
      en       = CTRL_EN_STALL;
      stall_ev = 1'b1;
      state_d  = ST_STALL;
      if (consec_q >= 32'(MAX_STALL)) err_d = 1'b1;
      if (consec_q != '1) consec_d = consec_q + 32'd1;
    end else begin
      en       = CTRL_EN_RUN;
      state_d  = ST_RUN;
      consec_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_RUN;
      saved_q  <= ST_RUN;
      cnt_q    <= 2'd0;
      consec_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
      err_q    <= err_d;
    end
  end

  assign o_ctrl_pc_en       = en.pc_en;
  assign o_ctrl_if_id_en    = en.if_id_en;
  assign o_ctrl_if_id_flush = en.if_id_flush;
  assign o_ctrl_id_ex_en    = en.id_ex_en;
  assign o_ctrl_id_ex_flush = en.id_ex_flush;
  assign o_ctrl_ex_mem_en   = en.ex_mem_en;
  assign o_ctrl_state       = state_q;
  assign o_ctrl_err         = err_q;

  sat_counter #(.W(32)) u_stall_cnt (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .inc_i (stall_ev),
    .clr_i (i_ctrl_cnt_clr),
    .cnt_o (o_ctrl_stall_cnt)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .inc_i (flush_ev),
    .clr_i (i_ctrl_cnt_clr),
    .cnt_o (o_ctrl_flush_cnt)
  );

  sat_counter #(.W(32)) u_freeze_cnt (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .inc_i (freeze_ev),
    .clr_i (i_ctrl_cnt_clr),
    .cnt_o (o_ctrl_freeze_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Vector-table and scoreboard bench for pipeline_ctrl (FLUSH_CYCLES=2, MAX_STALL=1).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, br = 1'b0, busy = 1'b0, clr = 1'b0;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
  logic        err;
  logic [5:0]  en_o;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(1)) dut (
    .i_clk                   (clk),
    .i_reset                 (rst),
    .i_ctrl_stall            (stall),
    .i_ctrl_br_taken_execute (br),
    .i_ctrl_mem_busy         (busy),
    .i_ctrl_cnt_clr          (clr),
    .o_ctrl_pc_en            (pc_en),
    .o_ctrl_if_id_en         (if_id_en),
    .o_ctrl_if_id_flush      (if_id_flush),
    .o_ctrl_id_ex_en         (id_ex_en),
    .o_ctrl_id_ex_flush      (id_ex_flush),
    .o_ctrl_ex_mem_en        (ex_mem_en),
    .o_ctrl_state            (state),
    .o_ctrl_stall_cnt        (stall_cnt),
    .o_ctrl_flush_cnt        (flush_cnt),
    .o_ctrl_freeze_cnt       (freeze_cnt),
    .o_ctrl_err              (err)
  );

  assign en_o = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
  localparam logic [5:0] E_RUN = 6'b110101;
  localparam logic [5:0] E_STL = 6'b000111;
  localparam logic [5:0] E_RDR = 6'b111111;
  localparam logic [5:0] E_FLS = 6'b111101;
  localparam logic [5:0] E_FRZ = 6'b000000;
  localparam logic [5:0] E_RST = 6'b001010;

  typedef struct {
    logic        stall, br, busy, clr;
    logic [5:0]  en;
    logic [1:0]  st;
    logic [31:0] sc, fc, zc;
    logic        err;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb_q[$];
  vec_t tbl[20];

  function automatic vec_t mk(input logic s, input logic b, input logic m, input logic c,
                              input logic [5:0] e, input logic [1:0] st,
                              input logic [31:0] sc, input logic [31:0] fc,
                              input logic [31:0] zc, input logic er);
    vec_t v;
    v.stall = s; v.br = b; v.busy = m; v.clr = c;
    v.en = e; v.st = st; v.sc = sc; v.fc = fc; v.zc = zc; v.err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input string nm);
    vec_t e;
    @(posedge clk);
    #1;
    stall = v.stall; br = v.br; busy = v.busy; clr = v.clr;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({nm, " en"},     {26'd0, en_o}, {26'd0, e.en});
    chk({nm, " state"},  {30'd0, state}, {30'd0, e.st});
    chk({nm, " stall_cnt"},  stall_cnt,  e.sc);
    chk({nm, " flush_cnt"},  flush_cnt,  e.fc);
    chk({nm, " freeze_cnt"}, freeze_cnt, e.zc);
    chk({nm, " err"},    {31'd0, err}, {31'd0, e.err});
  endtask

  task automatic reset_check(input string nm);
    chk({nm, " en"},     {26'd0, en_o}, {26'd0, E_RST});
    chk({nm, " state"},  {30'd0, state}, 32'd0);
    chk({nm, " counters"}, stall_cnt | flush_cnt | freeze_cnt, 32'd0);
    chk({nm, " err"},    {31'd0, err}, 32'd0);
  endtask

  // Assert reset in the middle of whatever state the last vector left behind.
  task automatic reset_pulse(input string nm);
    @(posedge clk);
    #1;
    stall = 1'b0; br = 1'b0; clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    reset_check(nm);
    @(posedge clk);
    #1;
    busy = 1'b0;
    rst  = 1'b0;
  endtask

  initial begin
    //              stl br bsy clr  en     st  sc fc zc err
    tbl[0]  = mk(0, 0, 0, 0, E_RUN, 2'd0, 1'd0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, E_STL, 2'd0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, E_RUN, 2'd1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, E_RUN, 2'd0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, E_RDR, 2'd0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, E_FLS, 2'd2, 1, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, E_RUN, 2'd0, 1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, E_RDR, 2'd0, 1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, E_FRZ, 2'd2, 1, 2, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, E_FRZ, 2'd3, 1, 2, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, E_FRZ, 2'd3, 1, 2, 2, 0);
    tbl[11] = mk(0, 0, 0, 0, E_FLS, 2'd3, 1, 2, 3, 0);
    tbl[12] = mk(0, 0, 0, 0, E_RUN, 2'd0, 1, 2, 3, 0);
    tbl[13] = mk(0, 1, 0, 0, E_RDR, 2'd0, 1, 2, 3, 0);
    tbl[14] = mk(0, 1, 0, 0, E_RDR, 2'd2, 1, 3, 3, 0);
    tbl[15] = mk(0, 0, 0, 0, E_FLS, 2'd2, 1, 4, 3, 0);
    tbl[16] = mk(0, 0, 0, 0, E_RUN, 2'd0, 1, 4, 3, 0);
    tbl[17] = mk(1, 0, 1, 0, E_FRZ, 2'd0, 1, 4, 3, 0);
    tbl[18] = mk(0, 0, 0, 0, E_RUN, 2'd3, 1, 4, 4, 0);
    tbl[19] = mk(0, 0, 0, 0, E_RUN, 2'd0, 1, 4, 4, 0);

    repeat (2) @(negedge clk);
    reset_check("por");
    rst = 1'b0;

    for (int i = 0; i < 20; i++) drive(tbl[i], $sformatf("v%0d", i));

    // Two back-to-back stalls exceed MAX_STALL=1; error is sticky.
    drive(mk(1, 0, 0, 0, E_STL, 2'd0, 1, 4, 4, 0), "err_s1");
    drive(mk(1, 0, 0, 0, E_STL, 2'd1, 2, 4, 4, 0), "err_s2");
    for (int i = 0; i < 10; i++)
      drive(mk(0, 0, 0, 0, E_RUN, (i == 0) ? 2'd1 : 2'd0, 3, 4, 4, 1), $sformatf("err_idle%0d", i));

    // Reset while a FLUSH countdown is pending.
    drive(mk(0, 1, 0, 0, E_RDR, 2'd0, 3, 4, 4, 1), "rf_br");
    reset_pulse("rst_in_flush");
    drive(mk(0, 0, 0, 0, E_RUN, 2'd0, 0, 0, 0, 0), "rf_after");

    // Reset while frozen.
    drive(mk(0, 0, 1, 0, E_FRZ, 2'd0, 0, 0, 0, 0), "rz_busy");
    reset_pulse("rst_in_freeze");
    drive(mk(0, 0, 0, 0, E_RUN, 2'd0, 0, 0, 0, 0), "rz_after");

    // Saturation and clear-over-increment.
    dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    drive(mk(1, 0, 0, 0, E_STL, 2'd0, 32'hFFFF_FFFE, 0, 0, 0), "sat_s1");
    drive(mk(1, 0, 0, 0, E_STL, 2'd1, 32'hFFFF_FFFF, 0, 0, 0), "sat_s2");
    drive(mk(1, 0, 0, 0, E_STL, 2'd1, 32'hFFFF_FFFF, 0, 0, 1), "sat_s3");
    drive(mk(1, 0, 0, 1, E_STL, 2'd1, 32'hFFFF_FFFF, 0, 0, 1), "clr_stall");
    drive(mk(0, 0, 0, 0, E_RUN, 2'd1, 0, 0, 0, 1), "clr_after1");
    drive(mk(0, 0, 0, 0, E_RUN, 2'd0, 0, 0, 0, 1), "clr_after2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
